// File: rtl/ir_pkg.sv
// Shared types and constants for the IR sensor front end (ir_intf and ir_bank).
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        COMMIT
    } ir_state_t;

    localparam int NUM_CH = 8;
    localparam int A2D_W  = 12;
    localparam int IDX_W  = 3;

    localparam int FAST_PERIOD_W = 10;
    localparam int FAST_SETTLE_W = 6;

    function automatic int pick_w(input int fast_sim, input int full_w, input int fast_w);
        return (fast_sim != 0) ? fast_w : full_w;
    endfunction

endpackage

// File: rtl/ir_bank.sv
// Shadow buffer filled one conversion at a time, and a committed bank that
// takes the whole shadow in one cycle so readers always see a coherent set.
module ir_bank
    import ir_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [A2D_W-1:0] wr_data,
    input  logic             commit,
    input  logic [IDX_W-1:0] sel,
    output logic [A2D_W-1:0] rd_data
);

    logic [A2D_W-1:0] shadow_q [NUM_CH];
    logic [A2D_W-1:0] shadow_d [NUM_CH];
    logic [A2D_W-1:0] bank_q   [NUM_CH];
    logic [A2D_W-1:0] bank_d   [NUM_CH];

    always_comb begin
        shadow_d = shadow_q;
        bank_d   = bank_q;
        if (wr_en) begin
            shadow_d[wr_idx] = wr_data;
        end
        if (commit) begin
            bank_d = shadow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '{default: '0};
            bank_q   <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            bank_q   <= bank_d;
        end
    end

    assign rd_data = bank_q[sel];

endmodule

// File: rtl/ir_intf.sv
// IR sensor front end: fires the emitters each period, sequences eight A2D
// conversions into a shadow buffer and commits them as one reading set.
module ir_intf
    import ir_pkg::*;
#(
    parameter int FAST_SIM = 0,
    parameter int PERIOD_W = 18,
    parameter int SETTLE_W = 12,
    parameter int TMO_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnv_cmplt,
    input  logic [A2D_W-1:0] res,
    input  logic [IDX_W-1:0] sel,
    output logic             strt_cnv,
    output logic [IDX_W-1:0] chnnl,
    output logic             IR_en,
    output logic             IR_vld,
    output logic [A2D_W-1:0] ir_rd,
    output logic             cnv_err
);

    localparam int PER_W = pick_w(FAST_SIM, PERIOD_W, FAST_PERIOD_W);
    localparam int SET_W = pick_w(FAST_SIM, SETTLE_W, FAST_SETTLE_W);

    ir_state_t        state_q, state_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ir_en_q, ir_en_d;
    logic             tick;
    logic             wr_en;
    logic             commit;
    logic             err;

    // Free-running period timer; a tick outside IDLE is simply lost.
    assign period_d = period_q + PER_W'(1);
    assign tick     = &period_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        wd_d     = wd_q;
        idx_d    = idx_q;
        ir_en_d  = ir_en_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = SETTLE;
                    ir_en_d  = 1'b1;
                    settle_d = '0;
                    idx_d    = '0;
                end
            end
            SETTLE: begin
                settle_d = settle_q + SET_W'(1);
                if (&settle_q) begin
                    state_d = START;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as a good conversion.
                if (cnv_cmplt) begin
                    wr_en = 1'b1;
                    if (idx_q == IDX_W'(NUM_CH - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = START;
                    end
                end else if (&wd_q) begin
                    err     = 1'b1;
                    ir_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + TMO_W'(1);
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                ir_en_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            settle_q <= '0;
            wd_q     <= '0;
            idx_q    <= '0;
            ir_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            settle_q <= settle_d;
            wd_q     <= wd_d;
            idx_q    <= idx_d;
            ir_en_q  <= ir_en_d;
        end
    end

    ir_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (res),
        .commit  (commit),
        .sel     (sel),
        .rd_data (ir_rd)
    );

    assign strt_cnv = (state_q == START);
    assign chnnl    = idx_q;
    assign IR_en    = ir_en_q;
    assign IR_vld   = (state_q == COMMIT);
    assign cnv_err  = err;

endmodule
